// File: rtl/mc_bus_pkg.sv
// Shared definitions for the MCU bus slave: default bus widths and the FSM state encoding.
package mc_bus_pkg;

    localparam int MC_DATA_WIDTH_DEF = 16;
    localparam int MC_ADD_WIDTH_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_REQ,
        ST_READ_CAP,
        ST_READ_HOLD
    } mc_state_e;

endpackage

// File: rtl/mc_sync.sv
// Multi-bit flop-chain synchronizer with configurable depth and reset value.
module mc_sync #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) sync_q[i] <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments let each stage take the previous stage's old value.
            sync_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/mc_bus_slave.sv
// Asynchronous MCU bus to single-cycle register strobe bridge.
// Define MC_BUS_SLAVE_ERR_CNT_EN to add the saturating protocol-violation counter err_cnt.
module mc_bus_slave
    import mc_bus_pkg::*;
#(
    parameter int MC_DATA_WIDTH = MC_DATA_WIDTH_DEF,
    parameter int MC_ADD_WIDTH  = MC_ADD_WIDTH_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_oe,
    input  logic                     mc_we,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
    output logic [MC_DATA_WIDTH-1:0] mc_data_out,
    output logic                     mc_data_oe,
    output logic [MC_ADD_WIDTH-1:0]  reg_add,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    output logic                     reg_wr_stb,
    output logic                     reg_rd_stb,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata
`ifdef MC_BUS_SLAVE_ERR_CNT_EN
    ,
    output logic [7:0]               err_cnt
`endif
);

    localparam int BUS_W = MC_ADD_WIDTH + MC_DATA_WIDTH;

    logic [2:0]               ctrl_s;
    logic                     ce_s, oe_s, we_s;
    logic [MC_ADD_WIDTH-1:0]  add_s;
    logic [MC_DATA_WIDTH-1:0] data_s;
    logic [BUS_W-1:0]         bus_dly_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0]   flush_q;
    logic                     sync_vld;
    logic                     wr_act, rd_act, viol, bus_idle;

    mc_state_e                state_q, state_d;
    logic                     armed_q, armed_d;
    logic                     wr_stb_q, wr_stb_d;
    logic                     rd_stb_q, rd_stb_d;
    logic [MC_ADD_WIDTH-1:0]  reg_add_q;
    logic [MC_DATA_WIDTH-1:0] reg_wdata_q;
    logic [MC_DATA_WIDTH-1:0] rdata_q;
    logic                     latch_add, latch_data, cap;

    mc_sync #(
        .WIDTH   (3),
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (3'b111)
    ) u_ctrl_sync (
        .clock (clock),
        .reset (reset),
        .d_i   ({mc_ce, mc_oe, mc_we}),
        .q_o   (ctrl_s)
    );

    assign {ce_s, oe_s, we_s} = ctrl_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the delay line is reset so reg_add/reg_wdata never pick up X after reset.
            for (int i = 0; i < SYNC_STAGES; i++) bus_dly_q[i] <= '0;
            flush_q <= '0;
        end else begin
            bus_dly_q[0] <= {mc_add, mc_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) bus_dly_q[i] <= bus_dly_q[i-1];
            flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign {add_s, data_s} = bus_dly_q[SYNC_STAGES-1];
    // Synchronizer outputs only reflect the real bus once the reset value has flushed out.
    assign sync_vld = flush_q[SYNC_STAGES-1];

    assign wr_act   = !ce_s && !we_s &&  oe_s;
    assign rd_act   = !ce_s && !oe_s &&  we_s;
    assign viol     = !ce_s && !oe_s && !we_s;
    assign bus_idle =  ce_s || (oe_s && we_s);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        armed_d    = (armed_q || (sync_vld && bus_idle)) && !viol;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        latch_add  = 1'b0;
        latch_data = 1'b0;
        cap        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (armed_q && wr_act) begin
                    state_d    = ST_WRITE;
                    latch_add  = 1'b1;
                    latch_data = 1'b1;
                end else if (armed_q && rd_act) begin
                    state_d   = ST_READ_REQ;
                    latch_add = 1'b1;
                    rd_stb_d  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wr_act) begin
                    latch_add  = 1'b1;
                    latch_data = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    wr_stb_d = !viol;
                end
            end
            ST_READ_REQ:  state_d = ST_READ_CAP;
            ST_READ_CAP: begin
                state_d = ST_READ_HOLD;
                cap     = 1'b1;
            end
            ST_READ_HOLD: if (!rd_act) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            reg_add_q   <= '0;
            reg_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            wr_stb_q <= wr_stb_d;
            rd_stb_q <= rd_stb_d;
            if (latch_add)  reg_add_q   <= add_s;
            if (latch_data) reg_wdata_q <= data_s;
            if (cap)        rdata_q     <= reg_rdata;
        end
    end

    // reg_rdata is passed straight through during capture to meet the read latency.
    assign mc_data_out = (state_q == ST_READ_CAP) ? reg_rdata : rdata_q;
    assign mc_data_oe  = rd_act && (state_q == ST_READ_REQ || state_q == ST_READ_CAP ||
                                    state_q == ST_READ_HOLD);
    assign reg_add     = reg_add_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_wr_stb  = wr_stb_q;
    assign reg_rd_stb  = rd_stb_q;

`ifdef MC_BUS_SLAVE_ERR_CNT_EN
    logic       viol_q;
    logic [7:0] err_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            viol_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            viol_q <= viol;
            if (viol && !viol_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mc_bus_slave.sv
// Directed self-checking bench for mc_bus_slave with a small register-file model.
module tb_mc_bus_slave;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int SS = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          mc_ce, mc_oe, mc_we;
    logic [AW-1:0] mc_add;
    logic [DW-1:0] mc_data_in;
    logic [DW-1:0] mc_data_out;
    logic          mc_data_oe;
    logic [AW-1:0] reg_add;
    logic [DW-1:0] reg_wdata;
    logic          reg_wr_stb, reg_rd_stb;
    logic [DW-1:0] reg_rdata;
`ifdef MC_BUS_SLAVE_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    mc_bus_slave #(
        .MC_DATA_WIDTH (DW),
        .MC_ADD_WIDTH  (AW),
        .SYNC_STAGES   (SS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mc_ce       (mc_ce),
        .mc_oe       (mc_oe),
        .mc_we       (mc_we),
        .mc_add      (mc_add),
        .mc_data_in  (mc_data_in),
        .mc_data_out (mc_data_out),
        .mc_data_oe  (mc_data_oe),
        .reg_add     (reg_add),
        .reg_wdata   (reg_wdata),
        .reg_wr_stb  (reg_wr_stb),
        .reg_rd_stb  (reg_rd_stb),
        .reg_rdata   (reg_rdata)
`ifdef MC_BUS_SLAVE_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            wr_stb_cyc = 0;
    int            rd_stb_cyc = 0;
    int            rel_cyc = 0;
    logic [AW-1:0] wr_add_log [32];
    logic [DW-1:0] wr_data_log [32];
    logic [DW-1:0] mem [64];

    always @(posedge clock) cyc <= cyc + 1;

    // Register-file model: read data appears the cycle after reg_rd_stb.
    always @(posedge clock) begin
        if (reg_rd_stb) reg_rdata <= mem[reg_add];
        if (reg_wr_stb) mem[reg_add] <= reg_wdata;
    end

    always @(negedge clock) begin
        if (reg_wr_stb) begin
            wr_add_log[wr_cnt % 32]  = reg_add;
            wr_data_log[wr_cnt % 32] = reg_wdata;
            wr_stb_cyc = cyc;
            wr_cnt++;
        end
        if (reg_rd_stb) begin
            rd_stb_cyc = cyc;
            rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_release();
        mc_ce = 1'b1;
        mc_oe = 1'b1;
        mc_we = 1'b1;
    endtask

    task automatic mcu_write(input logic [AW-1:0] add, input logic [DW-1:0] data, input int hold);
        mc_add     = add;
        mc_data_in = data;
        mc_ce      = 1'b0;
        mc_we      = 1'b0;
        tick(hold);
        mc_ce   = 1'b1;
        mc_we   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 32'(mc_data_out), 32'h0);
        check({tag, "_data_oe"},  32'(mc_data_oe),  32'h0);
        check({tag, "_reg_add"},  32'(reg_add),     32'h0);
        check({tag, "_wdata"},    32'(reg_wdata),   32'h0);
        check({tag, "_stbs"},     32'({reg_wr_stb, reg_rd_stb}), 32'h0);
`ifdef MC_BUS_SLAVE_ERR_CNT_EN
        check({tag, "_err_cnt"},  32'(err_cnt),     32'h0);
`endif
    endtask

    int wr0, rd0, start;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reg_rdata  = '0;
        reset      = 1'b0;
        mc_add     = '0;
        mc_data_in = '0;
        bus_release();
        tick(3);
        check_all_zero("reset");
        reset = 1'b1;
        tick(4);

        // Write 0xAA55 to 0x00
        wr0 = wr_cnt;
        mcu_write(6'h00, 16'hAA55, 5);
        tick(6);
        check("wr1_count", 32'(wr_cnt - wr0), 32'd1);
        check("wr1_add",   32'(wr_add_log[wr0 % 32]),  32'h00);
        check("wr1_data",  32'(wr_data_log[wr0 % 32]), 32'hAA55);
        check("wr1_latency", 32'(wr_stb_cyc - rel_cyc), 32'(SS + 1));

        // Read 0x00
        rd0 = rd_cnt;
        mc_add = 6'h00;
        mc_ce  = 1'b0;
        mc_oe  = 1'b0;
        start  = cyc;
        tick(4);
        check("rd1_stb_cycle", 32'(rd_stb_cyc - start), 32'(SS + 1));
        check("rd1_data_out",  32'(mc_data_out), 32'hAA55);
        check("rd1_data_oe",   32'(mc_data_oe),  32'h1);
        tick(3);
        check("rd1_hold_data", 32'(mc_data_out), 32'hAA55);
        check("rd1_hold_oe",   32'(mc_data_oe),  32'h1);
        bus_release();
        tick(2);
        check("rd1_oe_release", 32'(mc_data_oe), 32'h0);
        tick(4);
        check("rd1_count", 32'(rd_cnt - rd0), 32'd1);

        // Back-to-back writes with one idle cycle between
        wr0 = wr_cnt;
        mcu_write(6'h3F, 16'h1234, 4);
        tick(1);
        mcu_write(6'h01, 16'h5678, 4);
        tick(6);
        check("b2b_count", 32'(wr_cnt - wr0), 32'd2);
        check("b2b_add0",  32'(wr_add_log[wr0 % 32]),        32'h3F);
        check("b2b_data0", 32'(wr_data_log[wr0 % 32]),       32'h1234);
        check("b2b_add1",  32'(wr_add_log[(wr0 + 1) % 32]),  32'h01);
        check("b2b_data1", 32'(wr_data_log[(wr0 + 1) % 32]), 32'h5678);

        // Chip enable drops out one cycle into a read of 0x3F
        rd0 = rd_cnt;
        mc_add = 6'h3F;
        mc_ce  = 1'b0;
        mc_oe  = 1'b0;
        tick(1);
        mc_ce = 1'b1;
        tick(3);
        check("ce_abort_oe", 32'(mc_data_oe), 32'h0);
        mc_oe = 1'b1;
        tick(5);
        check("ce_abort_rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("ce_abort_captured", 32'(mc_data_out), 32'h1234);

        // Violation: ce, oe and we all low
        wr0 = wr_cnt;
        rd0 = rd_cnt;
`ifdef MC_BUS_SLAVE_ERR_CNT_EN
        check("viol_err_before", 32'(err_cnt), 32'd0);
`endif
        mc_ce = 1'b0;
        mc_oe = 1'b0;
        mc_we = 1'b0;
        tick(4);
        check("viol_data_oe", 32'(mc_data_oe), 32'h0);
        bus_release();
        tick(5);
        check("viol_no_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
`ifdef MC_BUS_SLAVE_ERR_CNT_EN
        check("viol_err_after", 32'(err_cnt), 32'd1);
`endif

        // Reset pulsed during a write to 0x05
        wr0 = wr_cnt;
        mc_add     = 6'h05;
        mc_data_in = 16'h1111;
        mc_ce      = 1'b0;
        mc_we      = 1'b0;
        tick(4);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick(2);
        reset = 1'b1;
        tick(6);
        bus_release();
        tick(6);
        check("rst_no_commit", 32'(wr_cnt - wr0), 32'd0);
        mcu_write(6'h05, 16'h00FF, 5);
        tick(6);
        check("rst_next_count", 32'(wr_cnt - wr0), 32'd1);
        check("rst_next_add",   32'(wr_add_log[wr0 % 32]),  32'h05);
        check("rst_next_data",  32'(wr_data_log[wr0 % 32]), 32'h00FF);

`ifdef MC_BUS_SLAVE_ERR_CNT_EN
        // 300 violations saturate the counter
        for (int i = 1; i <= 300; i++) begin
            mc_ce = 1'b0;
            mc_oe = 1'b0;
            mc_we = 1'b0;
            tick(3);
            bus_release();
            tick(3);
            if (i == 200) check("err_cnt_200", 32'(err_cnt), 32'd200);
        end
        tick(3);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
